move_entry_ctrl: RTL

Player move-entry controller for the chess screen. Turns debounced button levels into cursor motion, piece selection and destination selection, and walks the shared `move_state_t` sequence `PLAYER_SEL -> PIECE_SEL -> POS_SEL -> MOVE_VAL`. The completed from/to pair goes to the downstream move validator over a valid/ready handshake, and the block waits for the validator's verdict. It sits between the button debouncers / board RAM and the move validator, and publishes its state to the VGA overlay.

---
 rtl/move_entry_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/move_entry_ctrl.sv
// move_entry_ctrl: chess move entry from buttons to a valid/ready validator request.
// Define MOVE_ENTRY_AUTOREPEAT_EN to make held direction buttons auto-repeat.
module move_entry_ctrl #(
   parameter int REPEAT_CYCLES = 12_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] screen_state,
   input  logic       my_color,
   input  logic       my_turn,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_sel,
   input  logic       btn_cancel,
   output logic [5:0] board_rd_addr,
   input  logic [3:0] board_rd_piece,
   output logic       move_valid,
   input  logic       move_ready,
   output logic [5:0] move_from,
   output logic [5:0] move_to,
   input  logic       val_done,
   input  logic       val_ok,
   output logic [1:0] move_state,
   output logic [5:0] cursor,
   output logic [5:0] sel_sq,
   output logic       sel_active,
   output logic       move_accepted,
   output logic       move_rejected
);

   localparam logic [2:0] CHESS_SCREEN = 3'd2;

   localparam logic [1:0] PLAYER_SEL = 2'd0;
   localparam logic [1:0] PIECE_SEL  = 2'd1;
   localparam logic [1:0] POS_SEL    = 2'd2;
   localparam logic [1:0] MOVE_VAL   = 2'd3;

   if (REPEAT_CYCLES < 1) begin : g_cfg_chk
      $error("REPEAT_CYCLES must be at least 1");
   end

   logic [1:0] r_state;
   logic [5:0] r_cursor;
   logic [5:0] r_sel_sq;
   logic       r_sel_active;
   logic       r_move_valid;
   logic [5:0] r_move_from;
   logic [5:0] r_move_to;
   logic       r_accept;
   logic       r_reject;
   logic       r_hs_done;
   logic       r_sel_pend;
   logic       r_moved;
   logic [5:0] r_btn_q;

   logic [5:0] w_btn;
   logic [5:0] w_rise;
   logic       w_chess;
   logic       w_nav;
   logic [3:0] w_dir_ev;
   logic       w_step;
   logic [5:0] w_cur_nxt;
   logic [2:0] w_row;
   logic [2:0] w_col;
   logic       w_settled;
   logic       w_sel_evt;
   logic       w_sel_go;
   logic       w_own;
   logic       w_cancel;

   // bit order: {cancel, sel, right, left, down, up}
   assign w_btn = {btn_cancel, btn_sel, btn_right,
                   btn_left, btn_down, btn_up};
   assign w_rise = w_btn & ~r_btn_q;

   assign w_chess = (screen_state == CHESS_SCREEN);
   assign w_nav = w_chess && my_turn &&
                  ((r_state == PIECE_SEL) || (r_state == POS_SEL));

   assign w_row = r_cursor[5:3];
   assign w_col = r_cursor[2:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_q <= 6'd0;
      end else begin
         r_btn_q <= w_btn;
      end
   end

`ifdef MOVE_ENTRY_AUTOREPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

   logic [RW-1:0] r_rep_cnt;
   logic          w_held;
   logic          w_rep_hit;

   assign w_held = |w_btn[3:0];
   assign w_rep_hit = w_held &&
                      (r_rep_cnt == RW'(REPEAT_CYCLES - 1));

   // restarts on release and on every fresh direction edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rep_cnt <= '0;
      end else if (!w_held || (|w_rise[3:0]) || w_rep_hit) begin
         r_rep_cnt <= '0;
      end else begin
         r_rep_cnt <= r_rep_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      w_dir_ev = w_rise[3:0];
`ifdef MOVE_ENTRY_AUTOREPEAT_EN
      if ((w_dir_ev == 4'd0) && w_rep_hit) begin
         w_dir_ev = w_btn[3:0];
      end
`endif
   end

   assign w_step = w_nav && (|w_dir_ev);

   always_comb begin
      w_cur_nxt = r_cursor;
      if (w_step) begin
         priority case (1'b1)
            w_dir_ev[0]: w_cur_nxt = {w_row + 3'd1, w_col};
            w_dir_ev[1]: w_cur_nxt = {w_row - 3'd1, w_col};
            w_dir_ev[2]: w_cur_nxt = {w_row, w_col - 3'd1};
            w_dir_ev[3]: w_cur_nxt = {w_row, w_col + 3'd1};
            default:     w_cur_nxt = r_cursor;
         endcase
      end
   end

   // board data lags the address by one cycle after any cursor step
   assign w_settled = !r_moved;
   assign w_sel_evt = w_rise[4] || r_sel_pend;
   assign w_sel_go  = w_sel_evt && w_settled && !w_step;
   assign w_cancel  = w_rise[5];
   assign w_own = (board_rd_piece[2:0] != 3'd0) &&
                  (board_rd_piece[3] == my_color);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= PLAYER_SEL;
         r_cursor     <= 6'd12;
         r_sel_sq     <= 6'd0;
         r_sel_active <= 1'b0;
         r_move_valid <= 1'b0;
         r_move_from  <= 6'd0;
         r_move_to    <= 6'd0;
         r_accept     <= 1'b0;
         r_reject     <= 1'b0;
         r_hs_done    <= 1'b0;
         r_sel_pend   <= 1'b0;
         r_moved      <= 1'b0;
      end else begin
         r_accept   <= 1'b0;
         r_reject   <= 1'b0;
         r_sel_pend <= 1'b0;
         r_moved    <= w_step;
         r_cursor   <= w_cur_nxt;
         if (!w_chess) begin
            r_state      <= PLAYER_SEL;
            r_move_valid <= 1'b0;
            r_sel_active <= 1'b0;
            r_hs_done    <= 1'b0;
         end else begin
            unique case (r_state)
               PLAYER_SEL: begin
                  if (my_turn) begin
                     r_state <= PIECE_SEL;
                  end
               end
               PIECE_SEL: begin
                  if (!my_turn) begin
                     r_state      <= PLAYER_SEL;
                     r_sel_active <= 1'b0;
                  end else begin
                     r_sel_pend <= w_sel_evt && !w_sel_go;
                     if (w_sel_go && w_own) begin
                        r_sel_sq     <= r_cursor;
                        r_sel_active <= 1'b1;
                        r_state      <= POS_SEL;
                     end
                  end
               end
               POS_SEL: begin
                  if (!my_turn) begin
                     r_state      <= PLAYER_SEL;
                     r_sel_active <= 1'b0;
                  end else if (w_cancel) begin
                     r_state      <= PIECE_SEL;
                     r_sel_active <= 1'b0;
                  end else begin
                     r_sel_pend <= w_sel_evt && !w_sel_go;
                     if (w_sel_go) begin
                        if (r_cursor == r_sel_sq) begin
                           r_state      <= PIECE_SEL;
                           r_sel_active <= 1'b0;
                        end else if (w_own) begin
                           r_sel_sq <= r_cursor;
                        end else begin
                           r_move_from  <= r_sel_sq;
                           r_move_to    <= r_cursor;
                           r_move_valid <= 1'b1;
                           r_hs_done    <= 1'b0;
                           r_state      <= MOVE_VAL;
                        end
                     end
                  end
               end
               MOVE_VAL: begin
                  if (r_move_valid && move_ready) begin
                     r_move_valid <= 1'b0;
                     r_hs_done    <= 1'b1;
                  end else if (r_hs_done && val_done) begin
                     r_hs_done    <= 1'b0;
                     r_sel_active <= 1'b0;
                     if (val_ok) begin
                        r_accept <= 1'b1;
                        r_state  <= PLAYER_SEL;
                     end else begin
                        r_reject <= 1'b1;
                        r_state  <= PIECE_SEL;
                     end
                  end
               end
               default: r_state <= PLAYER_SEL;
            endcase
         end
      end
   end

   assign board_rd_addr = r_cursor;
   assign cursor        = r_cursor;
   assign move_state    = r_state;
   assign sel_sq        = r_sel_sq;
   assign sel_active    = r_sel_active;
   assign move_valid    = r_move_valid;
   assign move_from     = r_move_from;
   assign move_to       = r_move_to;
   assign move_accepted = r_accept;
   assign move_rejected = r_reject;

endmodule
